multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences a multicycle RV32I datapath.
//  - Datapath: shared memory, single ALU, IR/ALUOut/data registers.
//  - Replaces the single-cycle controller: same opcode/funct3/funct7b5/NZCV inputs.
//  - Adds per-state enables and mux selects. alu_control comes from an internal alu_decoder instance.
// PARAMETERS
//  BRANCH_FULL  1  1: beq,bne,blt,bge,bltu,bgeu; 0: beq only, other B-funct3 never taken
// PORTS
//  clk           in   1  clock, rising edge
//  rst_n         in   1  asynchronous reset, active-low
//  opcode        in   7  IR[6:0]
//  funct3        in   3  IR[14:12]
//  funct7b5      in   1  IR[30]
//  N,Z,C,V       in   1  ALU flags, combinational from current ALU operands
//  mem_ready     in   1  memory done (present only with MEM_WAIT_EN)
//  pc_write      out  1  PC register load enable
//  adr_sel       out  1  memory address: 0=PC, 1=ALUOut
//  ir_write      out  1  IR and oldPC load enable
//  mem_wren      out  1  data memory write enable
//  regfile_wren  out  1  register file write enable
//  result_sel    out  2  00=ALUOut, 01=mem data, 10=ALU result
//  alu_asel      out  2  00=PC, 01=oldPC, 10=rs1
//  alu_bsel      out  2  00=rs2, 01=ximm, 10=const 4
//  ximm_sel      out  2  00=I, 01=S, 10=B, 11=J
//  alu_control   out  4  from alu_decoder(alu_op, opcode[5], funct3, funct7b5)
//  instr_done    out  1  1-cycle pulse in last state of each instruction
//  illegal       out  1  high while in TRAP
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FETCH.
//  - During reset, pc_write, ir_write, mem_wren, regfile_wren, instr_done and illegal are all forced to 0.
//  - During reset, the selects show FETCH values: adr_sel=0, result_sel=10, alu_asel=00, alu_bsel=10, alu_op=00.
//  - Outputs decode from state only, except the branch pc_write. Any signal not listed for a state is 0.
//  - Internal alu_op: 00=add, 01=sub/compare, 10=funct-decoded.
//  - FETCH: adr_sel=0, ir_write, asel=00, bsel=10, alu_op=00, result_sel=10, pc_write. Next: DECODE.
//  - DECODE: asel=01, bsel=01, ximm_sel=10, alu_op=00 (branch target into ALUOut).
//    - lw/sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI.
//    - 1100011 -> BRANCH; 1101111 -> JAL; any other opcode -> TRAP.
//  - MEMADR: asel=10, bsel=01, alu_op=00; ximm_sel=00 for lw, 01 for sw. Next: MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: adr_sel=1, result_sel=00. Next: MEMWB.
//  - MEMWB: result_sel=01, regfile_wren, instr_done. Next: FETCH.
//  - MEMWRITE: adr_sel=1, result_sel=00, mem_wren, instr_done. Next: FETCH.
//  - EXECR: asel=10, bsel=00, alu_op=10. Next: ALUWB.
//  - EXECI: asel=10, bsel=01, ximm_sel=00, alu_op=10. Next: ALUWB.
//  - ALUWB: result_sel=00, regfile_wren, instr_done. Next: FETCH.
//  - BRANCH: asel=10, bsel=00, alu_op=01, result_sel=00, instr_done.
//    - pc_write = taken. Next: FETCH.
//    - taken: f3 000=Z, 001=~Z, 100=N^V, 101=~(N^V), 110=~C, 111=C.
//    - f3 010/011 never taken.
//  - JAL: asel=01, bsel=10, alu_op=00, result_sel=00, ximm_sel=11, pc_write. Next: ALUWB (link=oldPC+4).
//  - TRAP: illegal=1, all enables 0. Exit only via reset.
//  - Latency (cycles, FETCH to last state): lw 5; sw, R, I, jal 4; branch 3.
//  - Reset mid-instruction aborts immediately. No partial write occurs after rst_n falls.
//  - The opcode decode in DECODE/MEMADR uses IR contents, which are stable after FETCH.
// CONFIGURATION
//  MEM_WAIT_EN defined:
//  - mem_ready port exists. FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0.
//  - FETCH: ir_write and pc_write are asserted only in the cycle with mem_ready=1.
//  - MEMWRITE: mem_wren is held high until mem_ready. instr_done is gated with mem_ready.
//  MEM_WAIT_EN undefined:
//  - No mem_ready port; behaves as mem_ready=1 every cycle.
// TESTING
//  - Reset: rst_n=0 mid-MEMREAD -> state=FETCH, all enables 0. On release, FETCH outputs with pc_write=1.
//  - lw (0000011): FETCH,DECODE,MEMADR,MEMREAD,MEMWB -> regfile_wren only in cycle 5, result_sel=01, instr_done pulse.
//  - beq f3=000: Z=1 -> pc_write=1 in BRANCH (3 cycles); Z=0 -> pc_write=0.
//    BRANCH_FULL=1, blt: N=1,V=0 -> taken.
//  - jal (1101111): JAL asserts pc_write; ALUWB writes rd with result_sel=00; 4 cycles total.
//  - opcode 1111111 -> TRAP on cycle 3, illegal=1 for 10+ cycles, no enables; reset clears it.
//  - MEM_WAIT_EN, sw with mem_ready low 3 cycles -> mem_wren high 4 cycles, single instr_done, then FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the RV32I datapath (slave).
// The mem_ready wire exists only when MEM_WAIT_EN is defined.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       N;
  logic       Z;
  logic       C;
  logic       V;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write;
  logic       adr_sel;
  logic       ir_write;
  logic       mem_wren;
  logic       regfile_wren;
  logic [1:0] result_sel;
  logic [1:0] alu_asel;
  logic [1:0] alu_bsel;
  logic [1:0] ximm_sel;
  logic [3:0] alu_control;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, N, Z, C, V,
`ifdef MEM_WAIT_EN
    input  mem_ready,
`endif
    output pc_write, adr_sel, ir_write, mem_wren, regfile_wren, result_sel,
    output alu_asel, alu_bsel, ximm_sel, alu_control, instr_done, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, N, Z, C, V,
`ifdef MEM_WAIT_EN
    output mem_ready,
`endif
    input  pc_write, adr_sel, ir_write, mem_wren, regfile_wren, result_sel,
    input  alu_asel, alu_bsel, ximm_sel, alu_control, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32I datapath, with the ALU decoder folded in.
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on the mem_ready handshake.
module multicycle_controller #(
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus,
  output logic [3:0]                     dbg_state
);

  // Handshake: a memory access state completes in the cycle mem_ready=1;
  // until then the state and its selects are held and one-shot enables stay low.
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
    ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  state_t     state, state_next;
  logic       mem_rdy;
  logic       taken;
  logic [1:0] alu_op;
  logic       pc_write_s, ir_write_s, mem_wren_s, rf_wren_s, done_s, illegal_s;

`ifdef MEM_WAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:    if (mem_rdy) state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1100011:             state_next = BRANCH;
          7'b1101111:             state_next = JAL;
          default:                state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = bus.opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_rdy) state_next = MEMWB;
      MEMWRITE: if (mem_rdy) state_next = FETCH;
      EXECR, EXECI, JAL: state_next = (state == JAL || state == EXECR || state == EXECI) ? ALUWB : FETCH;
      MEMWB, ALUWB, BRANCH: state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // With BRANCH_FULL=0 only beq can redirect the PC.
  always_comb begin
    taken = 1'b0;
    if (BRANCH_FULL) begin
      case (bus.funct3)
        3'b000:  taken = bus.Z;
        3'b001:  taken = ~bus.Z;
        3'b100:  taken = bus.N ^ bus.V;
        3'b101:  taken = ~(bus.N ^ bus.V);
        3'b110:  taken = ~bus.C;
        3'b111:  taken = bus.C;
        default: taken = 1'b0;
      endcase
    end else begin
      taken = (bus.funct3 == 3'b000) && bus.Z;
    end
  end

  always_comb begin
    pc_write_s = 1'b0; ir_write_s = 1'b0; mem_wren_s = 1'b0;
    rf_wren_s  = 1'b0; done_s     = 1'b0; illegal_s  = 1'b0;
    bus.adr_sel    = 1'b0;
    bus.result_sel = 2'b00;
    bus.alu_asel   = 2'b00;
    bus.alu_bsel   = 2'b00;
    bus.ximm_sel   = 2'b00;
    alu_op         = 2'b00;
    unique case (state)
      FETCH: begin
        ir_write_s = mem_rdy; pc_write_s = mem_rdy;
        bus.alu_bsel = 2'b10; bus.result_sel = 2'b10;
      end
      DECODE: begin
        bus.alu_asel = 2'b01; bus.alu_bsel = 2'b01; bus.ximm_sel = 2'b10;
      end
      MEMADR: begin
        bus.alu_asel = 2'b10; bus.alu_bsel = 2'b01;
        bus.ximm_sel = bus.opcode[5] ? 2'b01 : 2'b00;
      end
      MEMREAD:  bus.adr_sel = 1'b1;
      MEMWB: begin
        bus.result_sel = 2'b01; rf_wren_s = 1'b1; done_s = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_sel = 1'b1; mem_wren_s = 1'b1; done_s = mem_rdy;
      end
      EXECR: begin
        bus.alu_asel = 2'b10; alu_op = 2'b10;
      end
      EXECI: begin
        bus.alu_asel = 2'b10; bus.alu_bsel = 2'b01; alu_op = 2'b10;
      end
      ALUWB: begin
        rf_wren_s = 1'b1; done_s = 1'b1;
      end
      BRANCH: begin
        bus.alu_asel = 2'b10; alu_op = 2'b01; pc_write_s = taken; done_s = 1'b1;
      end
      JAL: begin
        bus.alu_asel = 2'b01; bus.alu_bsel = 2'b10; bus.ximm_sel = 2'b11; pc_write_s = 1'b1;
      end
      TRAP:     illegal_s = 1'b1;
      default: ;
    endcase
  end

  // The async reset already selects FETCH; gating with rst_n also kills FETCH's own enables.
  assign bus.pc_write     = pc_write_s & rst_n;
  assign bus.ir_write     = ir_write_s & rst_n;
  assign bus.mem_wren     = mem_wren_s & rst_n;
  assign bus.regfile_wren = rf_wren_s  & rst_n;
  assign bus.instr_done   = done_s     & rst_n;
  assign bus.illegal      = illegal_s  & rst_n;

  always_comb begin
    bus.alu_control = ALU_ADD;
    case (alu_op)
      2'b01: bus.alu_control = ALU_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alu_control = (bus.opcode[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  bus.alu_control = ALU_SLL;
          3'b010:  bus.alu_control = ALU_SLT;
          3'b011:  bus.alu_control = ALU_SLTU;
          3'b100:  bus.alu_control = ALU_XOR;
          3'b101:  bus.alu_control = bus.funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  bus.alu_control = ALU_OR;
          default: bus.alu_control = ALU_AND;
        endcase
      end
      default: bus.alu_control = ALU_ADD;
    endcase
  end

endmodule
